aes_inv_round_ctrl: RTL and testbench
=====================================

// Module: aes_inv_round_ctrl
// PURPOSE
//  Sequencer for the AES inverse cipher (decryption) datapath; counterpart of the encryption round controller.
//  Runs the on-the-fly key schedule forward to the last round key, then steps it backward while it drives
//  the initial AddRoundKey, NR-1 full inverse rounds and a final round without InvMixColumns.
//  Sits between the decrypt top level (start/result handshake) and the inverse state and key registers.
// PARAMETERS
//  NR  10  number of cipher rounds (10/12/14 for AES-128/192/256)
//  CW  4   width of round/count outputs; must satisfy 2**CW > NR
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst_n      in   1   synchronous active-low reset
//  start      in   1   request one block decrypt; honoured only in IDLE
//  out_ready  in   1   downstream accepts plaintext
//  busy       out  1   high in every state except IDLE
//  key_load   out  1   load cipher key into key register (= start & IDLE)
//  key_fwd_en out  1   advance forward key expansion one step
//  key_inv_en out  1   step inverse key expansion one step (key i -> i-1)
//  in_ack     out  1   ciphertext captured; upstream may change data_in next cycle
//  sel        out  1   0: state reg <= data_in ^ key; 1: state reg <= round feedback
//  skip_mix   out  1   bypass InvMixColumns (final round)
//  reg_en     out  1   state register write enable
//  round      out  CW  round-key index currently applied / being generated
//  out_valid  out  1   plaintext valid on state register
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state<=IDLE, cnt<=0. Takes effect from any state, mid-operation included.
//    In IDLE all outputs are 0 except key_load, which follows start.
//  - Outputs decoded combinationally from state/cnt; key_load is the only Mealy output.
//  - IDLE:   start=1 -> KEYEXP, cnt<=1. start=0 -> stay.
//  - KEYEXP: key_fwd_en=1, busy=1, round=cnt. cnt<NR -> cnt+1. cnt==NR -> ADDK0, cnt<=NR.
//  - ADDK0:  sel=0, reg_en=1, in_ack=1, key_inv_en=1, round=NR. -> ROUND, cnt<=NR-1.
//  - ROUND:  sel=1, reg_en=1, skip_mix=0, key_inv_en=1, round=cnt.
//            cnt>1 -> cnt-1. cnt==1 -> FINAL, cnt<=0.
//  - FINAL:  sel=1, reg_en=1, skip_mix=1, key_inv_en=0, round=0. -> DONE.
//  - DONE:   out_valid=1, reg_en=0, busy=1, round=0. Stays until out_ready=1, then -> IDLE.
//  - start is ignored outside IDLE, including start=1 with out_ready=1 in DONE.
//    The next start is accepted no earlier than the first IDLE cycle.
//  - Timing, start sampled at edge T:
//    KEYEXP T+1..T+NR; ADDK0 T+NR+1; ROUND T+NR+2..T+2NR; FINAL T+2NR+1; out_valid from T+2NR+2.
//    For NR=10, out_valid rises at T+22.
//  - Counts: key_fwd_en high exactly NR cycles and key_inv_en high exactly NR cycles per block.
//    reg_en high exactly NR+1 cycles per block; skip_mix high exactly 1 cycle.
//  - Upstream holds data_in stable from start until in_ack. Downstream holds out_ready until
//    out_valid is seen; out_valid falls the cycle after the out_ready handshake.
//  - round never wraps: increments 1..NR, then decrements NR..0. No underflow below 0.
// TESTING
//  1 rst_n=0 for 2 cycles, then release -> IDLE; busy=out_valid=reg_en=key_*_en=0; round=0.
//  2 NR=10, start pulse at T, out_ready=1 ->
//    key_fwd_en T+1..T+10 with round 1..10; sel=0, in_ack=1 at T+11;
//    round 9..1 at T+12..T+20; skip_mix=1 at T+21; out_valid=1 at T+22; busy=0 at T+23.
//  3 out_ready=0 for 3 cycles in DONE -> out_valid stays 1 and reg_en stays 0 for all 3;
//    IDLE follows the cycle after out_ready=1.
//  4 start held high continuously -> second block's KEYEXP starts the cycle after IDLE is entered;
//    no start is accepted while busy=1.
//  5 rst_n=0 at round=5 in ROUND -> next cycle IDLE, all outputs 0; new start runs a full sequence.
//  6 NR=14, CW=4, single start -> 14 key_fwd_en cycles, 14 key_inv_en cycles;
//    out_valid at T+30; round covers 14..0.

Source files
------------

// File: rtl/aes_inv_round_ctrl.sv
// Round sequencer for the AES inverse cipher: forward key expansion to the last round key,
// then initial AddRoundKey, NR-1 inverse rounds and a final round without InvMixColumns.
`timescale 1ns/1ps
module aes_inv_round_ctrl #(
    parameter int unsigned NR = 10,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          out_ready,
    output logic          busy,
    output logic          key_load,
    output logic          key_fwd_en,
    output logic          key_inv_en,
    output logic          in_ack,
    output logic          sel,
    output logic          skip_mix,
    output logic          reg_en,
    output logic [CW-1:0] round,
    output logic          out_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StKeyExp,
        StAddK0,
        StRound,
        StFinal,
        StDone
    } state_e;

    localparam logic [CW-1:0] NrVal   = CW'(NR);
    localparam logic [CW-1:0] NrMin1  = CW'(NR - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StKeyExp;
                    cnt_d   = CntOne;
                end
            end
            StKeyExp: begin
                if (cnt_q < NrVal) begin
                    cnt_d = cnt_q + CntOne;
                end else begin
                    state_d = StAddK0;
                    cnt_d   = NrVal;
                end
            end
            StAddK0: begin
                state_d = StRound;
                cnt_d   = NrMin1;
            end
            StRound: begin
                // Compare against 1 rather than equality so the count can never wrap below 0.
                if (cnt_q > CntOne) begin
                    cnt_d = cnt_q - CntOne;
                end else begin
                    state_d = StFinal;
                    cnt_d   = '0;
                end
            end
            StFinal: begin
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy       = 1'b1;
        key_load   = 1'b0;
        key_fwd_en = 1'b0;
        key_inv_en = 1'b0;
        in_ack     = 1'b0;
        sel        = 1'b0;
        skip_mix   = 1'b0;
        reg_en     = 1'b0;
        round      = '0;
        out_valid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy     = 1'b0;
                key_load = start;
            end
            StKeyExp: begin
                key_fwd_en = 1'b1;
                round      = cnt_q;
            end
            StAddK0: begin
                reg_en     = 1'b1;
                in_ack     = 1'b1;
                key_inv_en = 1'b1;
                round      = NrVal;
            end
            StRound: begin
                sel        = 1'b1;
                reg_en     = 1'b1;
                key_inv_en = 1'b1;
                round      = cnt_q;
            end
            StFinal: begin
                sel      = 1'b1;
                reg_en   = 1'b1;
                skip_mix = 1'b1;
            end
            StDone: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: NR=10 and NR=14 instances checked every cycle against a
// timeline model, plus directed literal checks at hand-computed cycles.
`timescale 1ns/1ps
module tb_aes_inv_round_ctrl;

    logic       clk = 1'b0;
    logic [1:0] rst_n = 2'b00;
    logic [1:0] start = 2'b00;
    logic [1:0] out_ready = 2'b00;
    logic [1:0] busy, key_load, key_fwd_en, key_inv_en, in_ack, sel, skip_mix, reg_en, out_valid;
    logic [3:0] round_v [2];

    int checks = 0;
    int errors = 0;
    int cur = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    aes_inv_round_ctrl #(.NR(10), .CW(4)) u_dut10 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .out_ready(out_ready[0]),
        .busy(busy[0]), .key_load(key_load[0]), .key_fwd_en(key_fwd_en[0]),
        .key_inv_en(key_inv_en[0]), .in_ack(in_ack[0]), .sel(sel[0]), .skip_mix(skip_mix[0]),
        .reg_en(reg_en[0]), .round(round_v[0]), .out_valid(out_valid[0])
    );

    aes_inv_round_ctrl #(.NR(14), .CW(4)) u_dut14 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .out_ready(out_ready[1]),
        .busy(busy[1]), .key_load(key_load[1]), .key_fwd_en(key_fwd_en[1]),
        .key_inv_en(key_inv_en[1]), .in_ack(in_ack[1]), .sel(sel[1]), .skip_mix(skip_mix[1]),
        .reg_en(reg_en[1]), .round(round_v[1]), .out_valid(out_valid[1])
    );

    // Model: t counts cycles since the accepted start (t=1 is the first key expansion cycle).
    bit m_idle [2] = '{1'b1, 1'b1};
    int m_t    [2] = '{0, 0};

    function automatic int nr_of(int i);
        return (i == 0) ? 10 : 14;
    endfunction

    function automatic logic [12:0] obs_of(int i);
        return {busy[i], key_load[i], key_fwd_en[i], key_inv_en[i], in_ack[i], sel[i],
                skip_mix[i], reg_en[i], out_valid[i], round_v[i]};
    endfunction

    function automatic logic [12:0] exp_out(int nr, bit idle, int t, logic st);
        bit fwd, addk, rnd, fin, done;
        int r;
        if (idle) return {1'b0, st, 11'b0};
        fwd  = (t >= 1) && (t <= nr);
        addk = (t == nr + 1);
        rnd  = (t > nr + 1) && (t <= 2 * nr);
        fin  = (t == 2 * nr + 1);
        done = (t >= 2 * nr + 2);
        r    = fwd ? t : addk ? nr : rnd ? (2 * nr + 1 - t) : 0;
        return {1'b1, 1'b0, fwd, addk | rnd, addk, rnd | fin, fin, addk | rnd | fin, done, 4'(r)};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                m_idle[i] <= 1'b1;
                m_t[i]    <= 0;
            end else if (m_idle[i]) begin
                if (start[i]) begin
                    m_idle[i] <= 1'b0;
                    m_t[i]    <= 1;
                end
            end else if (m_t[i] >= 2 * nr_of(i) + 2) begin
                if (out_ready[i]) m_idle[i] <= 1'b1;
            end else begin
                m_t[i] <= m_t[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [12:0] e;
                e = exp_out(nr_of(i), m_idle[i], m_t[i], start[i]);
                checks++;
                if (obs_of(i) !== e) begin
                    errors++;
                    $display("FAIL model dut%0d t=%0d idle=%0b: got %b expected %b",
                             nr_of(i), m_t[i], m_idle[i], obs_of(i), e);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic start_blk(int i, bit hold);
        @(posedge clk);
        #1 start[i] = 1'b1;
        @(posedge clk);
        #1 if (!hold) start[i] = 1'b0;
        cur = 1;
    endtask

    task automatic goto(int k);
        while (cur < k) begin
            @(posedge clk);
            cur++;
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nf, ni, nreg, ns;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("t1 busy", 32'(busy[i]), 0);
            chk("t1 out_valid", 32'(out_valid[i]), 0);
            chk("t1 reg_en", 32'(reg_en[i]), 0);
            chk("t1 key_en", 32'(key_fwd_en[i] | key_inv_en[i]), 0);
            chk("t1 round", 32'(round_v[i]), 0);
        end
        @(posedge clk);
        #1 rst_n = 2'b11;

        // Single block, NR=10, downstream always ready.
        out_ready[0] = 1'b1;
        nf = 0; ni = 0; nreg = 0; ns = 0;
        start_blk(0, 1'b0);
        for (int k = 1; k <= 23; k++) begin
            goto(k);
            nf += 32'(key_fwd_en[0]); ni += 32'(key_inv_en[0]);
            nreg += 32'(reg_en[0]);   ns += 32'(skip_mix[0]);
            if (k == 1)  chk("t2 round T+1", 32'(round_v[0]), 1);
            if (k == 10) chk("t2 round T+10", 32'(round_v[0]), 10);
            if (k == 10) chk("t2 fwd T+10", 32'(key_fwd_en[0]), 1);
            if (k == 11) chk("t2 in_ack T+11", 32'(in_ack[0]), 1);
            if (k == 11) chk("t2 sel T+11", 32'(sel[0]), 0);
            if (k == 12) chk("t2 round T+12", 32'(round_v[0]), 9);
            if (k == 20) chk("t2 round T+20", 32'(round_v[0]), 1);
            if (k == 21) chk("t2 skip T+21", 32'(skip_mix[0]), 1);
            if (k == 22) chk("t2 out_valid T+22", 32'(out_valid[0]), 1);
            if (k == 23) chk("t2 busy T+23", 32'(busy[0]), 0);
        end
        chk("t2 fwd count", nf, 10);
        chk("t2 inv count", ni, 10);
        chk("t2 reg_en count", nreg, 11);
        chk("t2 skip count", ns, 1);

        // Downstream stalls three cycles in DONE.
        out_ready[0] = 1'b0;
        start_blk(0, 1'b0);
        for (int k = 22; k <= 25; k++) begin
            goto(k);
            chk("t3 out_valid held", 32'(out_valid[0]), 1);
            chk("t3 reg_en low", 32'(reg_en[0]), 0);
        end
        out_ready[0] = 1'b1;
        goto(26);
        chk("t3 idle after ready", 32'(busy[0]), 0);

        // start held high: ignored in DONE, accepted in the first IDLE cycle.
        start_blk(0, 1'b1);
        goto(22);
        chk("t4 out_valid", 32'(out_valid[0]), 1);
        goto(23);
        chk("t4 idle busy", 32'(busy[0]), 0);
        chk("t4 idle key_load", 32'(key_load[0]), 1);
        goto(24);
        chk("t4 second keyexp", 32'(key_fwd_en[0]), 1);
        chk("t4 second round", 32'(round_v[0]), 1);
        @(posedge clk);
        #1 start[0] = 1'b0;
        cur++;
        goto(45);
        chk("t4 second out_valid", 32'(out_valid[0]), 1);
        goto(46);
        chk("t4 second idle", 32'(busy[0]), 0);

        // Reset mid-round, then a full fresh block.
        start_blk(0, 1'b0);
        goto(16);
        chk("t5 round before reset", 32'(round_v[0]), 5);
        rst_n[0] = 1'b0;
        goto(17);
        chk("t5 busy after reset", 32'(busy[0]), 0);
        chk("t5 outputs after reset", 32'(obs_of(0)), 0);
        rst_n[0] = 1'b1;
        start_blk(0, 1'b0);
        goto(22);
        chk("t5 out_valid", 32'(out_valid[0]), 1);
        goto(23);
        chk("t5 idle", 32'(busy[0]), 0);

        // NR=14 instance.
        out_ready[1] = 1'b1;
        nf = 0; ni = 0; nreg = 0; ns = 0;
        start_blk(1, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            goto(k);
            nf += 32'(key_fwd_en[1]); ni += 32'(key_inv_en[1]);
            nreg += 32'(reg_en[1]);   ns += 32'(skip_mix[1]);
            if (k == 14) chk("t6 round T+14", 32'(round_v[1]), 14);
            if (k == 15) chk("t6 in_ack T+15", 32'(in_ack[1]), 1);
            if (k == 15) chk("t6 round T+15", 32'(round_v[1]), 14);
            if (k == 16) chk("t6 round T+16", 32'(round_v[1]), 13);
            if (k == 28) chk("t6 round T+28", 32'(round_v[1]), 1);
            if (k == 29) chk("t6 skip T+29", 32'(skip_mix[1]), 1);
            if (k == 30) chk("t6 out_valid T+30", 32'(out_valid[1]), 1);
            if (k == 31) chk("t6 busy T+31", 32'(busy[1]), 0);
        end
        chk("t6 fwd count", nf, 14);
        chk("t6 inv count", ni, 14);
        chk("t6 reg_en count", nreg, 15);
        chk("t6 skip count", ns, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
